// File: rtl/pipeline_stall_controller.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use stalls, data-memory freezes, branch flushes, post-reset flush window.
// Optional stall statistics counters are enabled by defining STALL_STATS_EN.
module pipeline_stall_controller #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             Branch_Taken,
    input  logic             EX_MEM_MemAccess,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
`ifdef STALL_STATS_EN
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
`endif
    output logic             mem_timeout
);

    localparam int MAX_C = (INIT_CYCLES > MEM_TIMEOUT) ? INIT_CYCLES : MEM_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use, mem_busy;
    logic          freeze, advance, lu_stall;

    assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    assign mem_busy = EX_MEM_MemAccess && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        freeze        = 1'b0;
        advance       = 1'b0;
        lu_stall      = 1'b0;
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        IF_ID_Flush   = 1'b1;
        ID_EX_Write   = 1'b0;
        ID_EX_Bubble  = 1'b1;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b1;

        case (state)
            INIT: begin
                IF_ID_Write  = 1'b1;
                ID_EX_Write  = 1'b1;
                EX_MEM_Write = 1'b1;
                if (cnt == INIT_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (mem_busy) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    freeze = 1'b1;
                    if (cnt == TO_LAST) state_nxt = ERR;
                    else                cnt_nxt   = cnt + 1'b1;
                end else begin
                    // Access completes: the pipe advances this very cycle under normal RUN rules.
                    advance   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            default: freeze = 1'b1;
        endcase

        if (freeze) begin
            IF_ID_Flush  = 1'b0;
            ID_EX_Bubble = 1'b0;
        end
        if (advance) begin
            PCWrite       = 1'b1;
            IF_ID_Write   = 1'b1;
            IF_ID_Flush   = 1'b0;
            ID_EX_Write   = 1'b1;
            ID_EX_Bubble  = 1'b0;
            EX_MEM_Write  = 1'b1;
            MEM_WB_Bubble = 1'b0;
            if (load_use) begin
                lu_stall     = 1'b1;
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end else if (Branch_Taken) begin
                IF_ID_Flush = 1'b1;
            end
        end

        // Outputs follow the asynchronous reset immediately, before state settles.
        if (!rst) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Write   = 1'b0;
            ID_EX_Bubble  = 1'b1;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
        end
    end

    assign mem_timeout = (state == ERR);

`ifdef STALL_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_stall_cnt <= '0;
            mem_stall_cnt  <= '0;
        end else begin
            if (lu_stall)                    load_stall_cnt <= sat_inc(load_stall_cnt);
            if (freeze && (state != ERR))    mem_stall_cnt  <= sat_inc(mem_stall_cnt);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (CNT_W > 0) & lu_stall;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; expected output vectors go through a scoreboard queue.
module tb_pipeline_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_EX_MemRead, IF_ID_UsesRt, Branch_Taken, EX_MEM_MemAccess, mem_ready;
    logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
    logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble;
    logic       EX_MEM_Write, MEM_WB_Bubble, mem_timeout;
`ifdef STALL_STATS_EN
    logic [15:0] load_stall_cnt, mem_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.INIT_CYCLES(4), .MEM_TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
        .Branch_Taken(Branch_Taken), .EX_MEM_MemAccess(EX_MEM_MemAccess), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Write(EX_MEM_Write),
        .MEM_WB_Bubble(MEM_WB_Bubble),
`ifdef STALL_STATS_EN
        .load_stall_cnt(load_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
`endif
        .mem_timeout(mem_timeout)
    );

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble, mem_timeout}
    logic [7:0] obs;
    assign obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
                  EX_MEM_Write, MEM_WB_Bubble, mem_timeout};

    localparam logic [7:0] V_RST  = 8'b0010_1010;
    localparam logic [7:0] V_INIT = 8'b0111_1110;
    localparam logic [7:0] V_NORM = 8'b1101_0100;
    localparam logic [7:0] V_LU   = 8'b0001_1100;
    localparam logic [7:0] V_BR   = 8'b1111_0100;
    localparam logic [7:0] V_FRZ  = 8'b0000_0010;
    localparam logic [7:0] V_ERR  = 8'b0000_0011;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;
    exp_t sb[$];

    task automatic cyc(input logic [7:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef STALL_STATS_EN
    task automatic chk_cnt(input logic [15:0] got, input logic [15:0] want, input string tag);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask
`endif

    task automatic idle_inputs();
        ID_EX_MemRead = 0; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0; IF_ID_UsesRt = 0;
        Branch_Taken = 0; EX_MEM_MemAccess = 0; mem_ready = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        cyc(V_RST, "reset0");
        cyc(V_RST, "reset1");

        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc(V_INIT, "init_flush");
        cyc(V_NORM, "run_first");

        ID_EX_MemRead = 1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
        cyc(V_LU, "lu_rs");
        ID_EX_MemRead = 0;
        cyc(V_NORM, "lu_rs_after");
        ID_EX_MemRead = 1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
        cyc(V_NORM, "lu_r0");

        ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd8; IF_ID_UsesRt = 0;
        cyc(V_NORM, "lu_rt_nouse");
        IF_ID_UsesRt = 1;
        cyc(V_LU, "lu_rt_use");
        ID_EX_MemRead = 0;
        cyc(V_NORM, "lu_rt_after");

        idle_inputs();
        Branch_Taken = 1;
        cyc(V_BR, "branch");
        Branch_Taken = 0;
        cyc(V_NORM, "branch_after");

        EX_MEM_MemAccess = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cyc(V_FRZ, "mem_freeze");
        mem_ready = 1;
`ifdef STALL_STATS_EN
        #1;
        chk_cnt(mem_stall_cnt, 16'd3, "mem_stall_cnt");
        chk_cnt(load_stall_cnt, 16'd2, "load_stall_cnt");
`endif
        cyc(V_NORM, "mem_release");
        EX_MEM_MemAccess = 0; mem_ready = 0;
        cyc(V_NORM, "mem_after");

        EX_MEM_MemAccess = 1; mem_ready = 0;
        ID_EX_MemRead = 1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; Branch_Taken = 1;
        cyc(V_FRZ, "combo_freeze0");
        cyc(V_FRZ, "combo_freeze1");
        mem_ready = 1;
        cyc(V_LU, "combo_lu");
        EX_MEM_MemAccess = 0; mem_ready = 0; ID_EX_MemRead = 0;
        cyc(V_BR, "combo_flush");
        Branch_Taken = 0;
        cyc(V_NORM, "combo_after");

        idle_inputs();
        EX_MEM_MemAccess = 1; mem_ready = 0;
        for (int i = 0; i < 64; i++) cyc(V_FRZ, "to_wait");
        cyc(V_ERR, "to_err");
        EX_MEM_MemAccess = 0; mem_ready = 1;
        cyc(V_ERR, "err_sticky0");
        Branch_Taken = 1;
        cyc(V_ERR, "err_sticky1");

        rst = 1'b0;
        cyc(V_RST, "err_reset");
        rst = 1'b1;
        idle_inputs();
`ifdef STALL_STATS_EN
        chk_cnt(mem_stall_cnt, 16'd0, "stats_cleared");
`endif
        for (int i = 0; i < 4; i++) cyc(V_INIT, "reinit");
        cyc(V_NORM, "rerun");

        EX_MEM_MemAccess = 1; mem_ready = 0;
        cyc(V_FRZ, "midacc_freeze0");
        cyc(V_FRZ, "midacc_freeze1");
        rst = 1'b0;
        cyc(V_RST, "midacc_reset");
        rst = 1'b1;
        cyc(V_INIT, "midacc_init");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
